// File: rtl/sensor_pkg.sv
// Shared definitions for the sensor poll scheduler: command codes, table size
// and the scheduler FSM state encoding.
package sensor_pkg;

  localparam int N_ADDR  = 32;
  localparam int N_ENTRY = 2 * N_ADDR;

  localparam logic [7:0] CMD_STATUS = 8'd1;
  localparam logic [7:0] CMD_READ_T = 8'd2;
  localparam logic [7:0] CMD_READ_H = 8'd3;
  localparam logic [7:0] CMD_MON_T  = 8'd4;
  localparam logic [7:0] CMD_MON_H  = 8'd5;
  localparam logic [7:0] CMD_STOP_T = 8'd6;
  localparam logic [7:0] CMD_STOP_H = 8'd7;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } state_t;

  // One-shot commands occupy the single pending slot instead of the tables.
  function automatic logic is_one_shot(input logic [7:0] code);
    return (code == CMD_STATUS) || (code == CMD_READ_T) || (code == CMD_READ_H);
  endfunction

endpackage

// File: rtl/rr_pick64.sv
// Round-robin picker: returns the first set bit of req_mask strictly after
// 'last', wrapping 63 -> 0; 'last' itself is considered only as the final candidate.
module rr_pick64 (
  input  logic [63:0] req_mask,
  input  logic [5:0]  last,
  output logic        found,
  output logic [5:0]  index
);

  always_comb begin
    logic [5:0] cand;
    found = 1'b0;
    index = 6'd0;
    cand  = 6'd0;
    for (int k = 1; k <= 64; k++) begin
      cand = last + 6'(k);
      if (!found && req_mask[cand]) begin
        found = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/sensor_poll_scheduler.sv
// Feeds one-shot and continuous-monitoring sensor reads to the shared sensor
// controller, one transaction at a time, with round-robin fairness and an idle gap.
module sensor_poll_scheduler
  import sensor_pkg::*;
#(
  parameter int GAP_CYCLES = 100_000_000,
  parameter int CNT_W      = 27
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_code,
  input  logic [7:0] cmd_addr,
  output logic       cmd_ack,
  output logic       cmd_reject,
  output logic       req_valid,
  output logic [7:0] req_code,
  output logic [4:0] req_addr,
  input  logic       req_ready,
  input  logic       done,
  output logic [5:0] active_count,
  output logic       busy
);

  state_t state_reg, state_next;
  logic [CNT_W-1:0] gap_cnt_reg, gap_cnt_next;

  logic [N_ADDR-1:0] mon_t_reg, mon_t_next;
  logic [N_ADDR-1:0] mon_h_reg, mon_h_next;

  logic       slot_valid_reg, slot_valid_next;
  logic [7:0] slot_code_reg, slot_code_next;
  logic [4:0] slot_addr_reg, slot_addr_next;

  logic       src_slot_reg, src_slot_next;
  logic [5:0] last_e_reg, last_e_next;
  logic [7:0] req_code_reg, req_code_next;
  logic [4:0] req_addr_reg, req_addr_next;
  logic       cmd_ack_reg, cmd_ack_next;
  logic       cmd_reject_reg, cmd_reject_next;

  logic [N_ENTRY-1:0] entry_mask;
  logic               pick_found;
  logic [5:0]         pick_index;
  logic               transfer;
  logic [6:0]         entry_count;

  // Entry e = {addr, kind}: even bits are temperature, odd bits humidity.
  generate
    for (genvar gi = 0; gi < N_ADDR; gi++) begin : g_entry
      assign entry_mask[2*gi]   = mon_t_reg[gi];
      assign entry_mask[2*gi+1] = mon_h_reg[gi];
    end
  endgenerate

  rr_pick64 u_pick (
    .req_mask (entry_mask),
    .last     (last_e_reg),
    .found    (pick_found),
    .index    (pick_index)
  );

  assign transfer = (state_reg == ISSUE) && req_ready;

  // The port is 6 bits wide; a completely full table reads as 63.
  always_comb begin
    entry_count = 7'd0;
    for (int k = 0; k < N_ENTRY; k++) begin
      entry_count = entry_count + 7'(entry_mask[k]);
    end
  end
  assign active_count = entry_count[6] ? 6'd63 : entry_count[5:0];

  // Command decode and table/slot update.
  always_comb begin
    mon_t_next      = mon_t_reg;
    mon_h_next      = mon_h_reg;
    slot_valid_next = slot_valid_reg;
    slot_code_next  = slot_code_reg;
    slot_addr_next  = slot_addr_reg;
    cmd_ack_next    = 1'b0;
    cmd_reject_next = 1'b0;

    if (transfer && src_slot_reg) begin
      slot_valid_next = 1'b0;
    end

    if (cmd_valid) begin
      if (cmd_code == 8'd0 || cmd_code > CMD_STOP_H || cmd_addr >= 8'(N_ADDR)) begin
        cmd_reject_next = 1'b1;
      end else if (is_one_shot(cmd_code)) begin
        // The registered slot flag is used, so a slot draining this cycle still counts as full.
        if (slot_valid_reg) begin
          cmd_reject_next = 1'b1;
        end else begin
          cmd_ack_next    = 1'b1;
          slot_valid_next = 1'b1;
          slot_code_next  = cmd_code;
          slot_addr_next  = cmd_addr[4:0];
        end
      end else begin
        cmd_ack_next = 1'b1;
        case (cmd_code)
          CMD_MON_T:  mon_t_next[cmd_addr[4:0]] = 1'b1;
          CMD_MON_H:  mon_h_next[cmd_addr[4:0]] = 1'b1;
          CMD_STOP_T: mon_t_next[cmd_addr[4:0]] = 1'b0;
          default:    mon_h_next[cmd_addr[4:0]] = 1'b0;
        endcase
      end
    end
  end

  // Scheduler FSM: next state and outputs.
  always_comb begin
    state_next    = state_reg;
    gap_cnt_next  = gap_cnt_reg;
    req_code_next = req_code_reg;
    req_addr_next = req_addr_reg;
    src_slot_next = src_slot_reg;
    last_e_next   = last_e_reg;
    req_valid     = 1'b0;
    busy          = 1'b1;

    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (slot_valid_reg) begin
          req_code_next = slot_code_reg;
          req_addr_next = slot_addr_reg;
          src_slot_next = 1'b1;
          state_next    = ISSUE;
        end else if (pick_found) begin
          req_code_next = pick_index[0] ? CMD_MON_H : CMD_MON_T;
          req_addr_next = pick_index[5:1];
          src_slot_next = 1'b0;
          last_e_next   = pick_index;
          state_next    = ISSUE;
        end
      end
      ISSUE: begin
        req_valid = 1'b1;
        if (req_ready) begin
          state_next = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (done) begin
          gap_cnt_next = '0;
          state_next   = GAP;
        end
      end
      default: begin
        if (gap_cnt_reg == CNT_W'(GAP_CYCLES - 1)) begin
          state_next = IDLE;
        end else begin
          gap_cnt_next = gap_cnt_reg + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= IDLE;
      gap_cnt_reg    <= '0;
      mon_t_reg      <= '0;
      mon_h_reg      <= '0;
      slot_valid_reg <= 1'b0;
      slot_code_reg  <= 8'd0;
      slot_addr_reg  <= 5'd0;
      src_slot_reg   <= 1'b0;
      last_e_reg     <= 6'd63;
      req_code_reg   <= 8'd0;
      req_addr_reg   <= 5'd0;
      cmd_ack_reg    <= 1'b0;
      cmd_reject_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      gap_cnt_reg    <= gap_cnt_next;
      mon_t_reg      <= mon_t_next;
      mon_h_reg      <= mon_h_next;
      slot_valid_reg <= slot_valid_next;
      slot_code_reg  <= slot_code_next;
      slot_addr_reg  <= slot_addr_next;
      src_slot_reg   <= src_slot_next;
      last_e_reg     <= last_e_next;
      req_code_reg   <= req_code_next;
      req_addr_reg   <= req_addr_next;
      cmd_ack_reg    <= cmd_ack_next;
      cmd_reject_reg <= cmd_reject_next;
    end
  end

  assign req_code   = req_code_reg;
  assign req_addr   = req_addr_reg;
  assign cmd_ack    = cmd_ack_reg;
  assign cmd_reject = cmd_reject_reg;

endmodule

// File: tb/tb_sensor_poll_scheduler.sv
// Randomized self-checking bench for sensor_poll_scheduler against a timestamp-based
// behavioural model of tables, one-shot slot and round-robin order.
module tb_sensor_poll_scheduler;

  localparam int GAP = 8;

  logic       clock = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic [7:0] cmd_code;
  logic [7:0] cmd_addr;
  logic       cmd_ack;
  logic       cmd_reject;
  logic       req_valid;
  logic [7:0] req_code;
  logic [4:0] req_addr;
  logic       req_ready;
  logic       done;
  logic [5:0] active_count;
  logic       busy;

  sensor_poll_scheduler #(.GAP_CYCLES(GAP), .CNT_W(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_code     (cmd_code),
    .cmd_addr     (cmd_addr),
    .cmd_ack      (cmd_ack),
    .cmd_reject   (cmd_reject),
    .req_valid    (req_valid),
    .req_code     (req_code),
    .req_addr     (req_addr),
    .req_ready    (req_ready),
    .done         (done),
    .active_count (active_count),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: tables, pending slot, and when the scheduler may next decide.
  bit         m_t[32];
  bit         m_h[32];
  bit         s_v;
  logic [7:0] s_code;
  logic [4:0] s_addr;
  int         last_e;
  bit         m_out;      // a transaction is issued or awaiting done
  bit         m_iss;      // request currently presented
  bit         m_src;
  logic [7:0] m_code;
  logic [4:0] m_addr;
  int         ready_at;   // first cycle in which a new selection may be made
  int         cyc;
  bit         e_ack, e_rej;
  int         n_req;

  function automatic int count_active();
    int c = 0;
    for (int i = 0; i < 32; i++) c += m_t[i] + m_h[i];
    return (c > 63) ? 63 : c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_t[i] = 0;
      m_h[i] = 0;
    end
    s_v = 0; s_code = 0; s_addr = 0; last_e = 63;
    m_out = 0; m_iss = 0; m_src = 0; m_code = 0; m_addr = 0;
    ready_at = 0; e_ack = 0; e_rej = 0;
  endtask

  task automatic model_tick(input bit rst, input bit cv, input logic [7:0] code,
                            input logic [7:0] addr, input bit rdy, input bit dn);
    bit dec = 0;
    bit clr_slot = 0;
    int pick = -1;
    logic [7:0] d_code = 0;
    logic [4:0] d_addr = 0;
    bit d_src = 0;
    if (rst) begin
      model_reset();
      cyc++;
      return;
    end
    e_ack = 0;
    e_rej = 0;
    // Selection sees the tables as they were before this cycle's command.
    if (!m_out && cyc >= ready_at) begin
      if (s_v) begin
        dec = 1; d_code = s_code; d_addr = s_addr; d_src = 1;
      end else begin
        for (int off = 1; off <= 64; off++) begin
          int e = (last_e + off) % 64;
          if (pick < 0 && ((e % 2) ? m_h[e / 2] : m_t[e / 2])) pick = e;
        end
        if (pick >= 0) begin
          dec = 1; d_code = (pick % 2) ? 8'd5 : 8'd4; d_addr = 5'(pick / 2); d_src = 0;
        end
      end
    end
    if (m_iss) begin
      if (rdy) begin
        m_iss = 0;
        clr_slot = m_src;
      end
    end else if (m_out && dn) begin
      m_out = 0;
      ready_at = cyc + GAP + 1;
    end
    if (cv) begin
      if (code == 0 || code > 7 || addr >= 32) e_rej = 1;
      else if (code <= 3) begin
        if (s_v) e_rej = 1;
        else begin
          e_ack = 1; s_v = 1; s_code = code; s_addr = addr[4:0];
        end
      end else begin
        e_ack = 1;
        case (code)
          8'd4: m_t[addr] = 1;
          8'd5: m_h[addr] = 1;
          8'd6: m_t[addr] = 0;
          default: m_h[addr] = 0;
        endcase
      end
    end
    if (clr_slot) s_v = 0;
    if (dec) begin
      m_out = 1; m_iss = 1; m_src = d_src; m_code = d_code; m_addr = d_addr;
      if (!d_src) last_e = pick;
      n_req++;
    end
    cyc++;
  endtask

  // One clock: drive at negedge, advance model, compare shortly after the posedge.
  task automatic cycle(input bit rst, input bit cv, input logic [7:0] code,
                       input logic [7:0] addr, input bit rdy, input bit dn);
    @(negedge clock);
    reset = rst; cmd_valid = cv; cmd_code = code; cmd_addr = addr;
    req_ready = rdy; done = dn;
    model_tick(rst, cv, code, addr, rdy, dn);
    @(posedge clock);
    #1;
    check_val("cmd_ack", cmd_ack, e_ack);
    check_val("cmd_reject", cmd_reject, e_rej);
    check_val("req_valid", req_valid, m_iss);
    check_val("busy", busy, m_out || (cyc < ready_at));
    check_val("active_count", active_count, count_active());
    if (m_iss) begin
      check_val("req_code", req_code, m_code);
      check_val("req_addr", req_addr, m_addr);
    end
  endtask

  task automatic rand_cycle(input bit allow_cmd);
    bit cv = allow_cmd && ($urandom_range(0, 3) == 0);
    logic [7:0] code = 8'($urandom_range(0, 8));
    logic [7:0] addr = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(32, 255))
                                                   : 8'($urandom_range(0, 7));
    cycle(0, cv, code, addr, $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0);
  endtask

  initial begin
    reset = 1; cmd_valid = 0; cmd_code = 0; cmd_addr = 0; req_ready = 0; done = 0;
    cyc = 0; n_req = 0;
    model_reset();
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    check_val("rst_req_code", req_code, 0);
    check_val("rst_req_addr", req_addr, 0);

    // One-shot read, served then followed by a full gap with nothing pending.
    cycle(0, 1, 8'd2, 8'd3, 0, 0);
    for (int i = 0; i < 20; i++) cycle(0, 0, 0, 0, 1, 1);

    // Three monitor entries, round-robin with the controller always ready.
    cycle(0, 1, 8'd4, 8'd1, 1, 0);
    cycle(0, 1, 8'd5, 8'd1, 1, 0);
    cycle(0, 1, 8'd4, 8'd7, 1, 0);
    for (int i = 0; i < 60; i++) cycle(0, 0, 0, 0, 1, (i % 5) == 4);

    // Illegal commands and a second one-shot while the slot is full.
    cycle(0, 1, 8'd0, 8'd1, 0, 0);
    cycle(0, 1, 8'd8, 8'd1, 0, 0);
    cycle(0, 1, 8'd4, 8'd32, 0, 0);
    cycle(0, 1, 8'd1, 8'd9, 0, 0);
    cycle(0, 1, 8'd3, 8'd2, 0, 0);
    // Stop (4,1) while transactions are in flight, then let things drain.
    cycle(0, 1, 8'd6, 8'd1, 0, 0);
    for (int i = 0; i < 60; i++) cycle(0, 0, 0, 0, 1, (i % 3) == 2);

    for (int i = 0; i < 3000; i++) rand_cycle(1);

    // Reset while a request is presented and the controller never accepts.
    cycle(0, 1, 8'd4, 8'd2, 0, 0);
    begin
      int waited = 0;
      while (!m_iss && waited < 200) begin
        cycle(0, 0, 0, 0, 0, 1);
        waited++;
      end
    end
    check_val("issue_reached", m_iss, 1);
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 40; i++) rand_cycle(0);
    check_val("post_rst_count", active_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
